// File: rtl/fetch_pkg.sv
// Shared definitions for the LEGv8 fetch front end: FSM encoding, next-PC
// select codes (also used by the control unit) and the default reset PC.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } fetch_state_e;

    localparam logic [1:0] PC_INC    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_REG    = 2'b10;
    localparam logic [1:0] PC_HOLD   = 2'b11;

    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

    // Register branch targets are word-aligned by discarding the low two bits.
    localparam logic [63:0] WORD_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFC;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory req/ack bus; the fetch unit is the master.
interface instruction_fetch_unit_if;

    logic [63:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: pc+4, pc+(K<<2), aligned register target,
// or hold. All adds wrap silently modulo 2^64.
module pc_next_logic
    import fetch_pkg::*;
#(
    parameter int K_bits = 64
) (
    input  logic        [63:0]       pc,
    input  logic        [1:0]        pc_sel,
    input  logic signed [K_bits-1:0] k,
    input  logic        [63:0]       reg_target,
    output logic        [63:0]       pc_plus4,
    output logic        [63:0]       next_pc
);

    logic signed [63:0] k_ext;
    logic        [63:0] branch_target;
    logic        [63:0] reg_aligned;

    // K arrives in words; bring it to exactly 64 bits before scaling.
    generate
        if (K_bits >= 64) begin : g_k_trunc
            assign k_ext = k[63:0];
        end else begin : g_k_sext
            assign k_ext = {{(64 - K_bits){k[K_bits-1]}}, k};
        end
    endgenerate

    assign pc_plus4      = pc + 64'd4;
    assign branch_target = pc + ($unsigned(k_ext) << 2);
    assign reg_aligned   = reg_target & WORD_ALIGN_MASK;

    always_comb begin
        next_pc = pc;
        unique case (pc_sel)
            PC_INC:    next_pc = pc_plus4;
            PC_BRANCH: next_pc = branch_target;
            PC_REG:    next_pc = reg_aligned;
            PC_HOLD:   next_pc = pc;
            default:   next_pc = pc;
        endcase
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Multi-cycle LEGv8 fetch front end: owns PC, instruction register and the
// architectural status flags; fetches over req/ack and retires on command.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          K_bits   = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    instruction_fetch_unit_if.master   imem,
    output logic        [31:0]         instruction,
    output logic                       instr_valid,
    output logic        [63:0]         pc,
    output logic        [63:0]         pc_plus4,
    output logic        [3:0]          status,
    input  logic                       retire,
    input  logic        [1:0]          pc_sel,
    input  logic signed [K_bits-1:0]   K,
    input  logic        [63:0]         reg_target,
    input  logic                       status_we,
    input  logic        [3:0]          alu_flags
);

    fetch_state_e state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [3:0]   status_q, status_d;
    logic [63:0]  next_pc;

    pc_next_logic #(
        .K_bits (K_bits)
    ) u_pc_next (
        .pc         (pc_q),
        .pc_sel     (pc_sel),
        .k          (K),
        .reg_target (reg_target),
        .pc_plus4   (pc_plus4),
        .next_pc    (next_pc)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: if (imem.imem_ack) state_d = ST_EXEC;
            ST_EXEC:  if (retire)        state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        imem.imem_req = (state_q == ST_FETCH);
        instr_valid   = (state_q == ST_EXEC);
    end

    // Ack is only honoured in FETCH and retire only in EXEC; anything else is dropped.
    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        status_d = status_q;
        if (state_q == ST_FETCH && imem.imem_ack) begin
            instr_d = imem.imem_rdata;
        end
        if (state_q == ST_EXEC && retire) begin
            pc_d = next_pc;
            if (status_we) begin
                status_d = alu_flags;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            instr_q  <= 32'h0;
            status_q <= 4'b0000;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            status_q <= status_d;
        end
    end

    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    assign instruction    = instr_q;
    assign status         = status_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: table-driven retire vectors plus hand
// sequences for reset, wait states, ignored inputs and reset mid-fetch.
module tb_instruction_fetch_unit;
    import fetch_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [63:0] pc, pc_plus4;
    logic [3:0]  status;
    logic        retire;
    logic [1:0]  pc_sel;
    logic [63:0] K;
    logic [63:0] reg_target;
    logic        status_we;
    logic [3:0]  alu_flags;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit dut (
        .clock       (clock),
        .reset       (reset),
        .imem        (bus),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .status      (status),
        .retire      (retire),
        .pc_sel      (pc_sel),
        .K           (K),
        .reg_target  (reg_target),
        .status_we   (status_we),
        .alu_flags   (alu_flags)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_instr_q[$];
    logic [63:0] exp_addr_q[$];
    logic [3:0]  cur_status;

    typedef struct {
        logic [63:0] start_pc;
        logic [1:0]  sel;
        logic [63:0] k;
        logic [63:0] tgt;
        logic        swe;
        logic [3:0]  flags;
        logic [63:0] exp_pc;
        logic [3:0]  exp_status;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Called with the DUT in FETCH, just after an edge.
    task automatic do_fetch(input logic [31:0] word, input int wait_cycles, input logic poke_retire);
        logic [63:0] addr0;
        addr0 = bus.imem_addr;
        check("fetch_req", {63'd0, bus.imem_req}, 64'd1);
        for (int i = 0; i < wait_cycles; i++) begin
            bus.imem_ack = 1'b0;
            if (poke_retire) begin
                retire = 1'b1; pc_sel = PC_BRANCH; K = 64'd5;
                status_we = 1'b1; alu_flags = ~cur_status;
            end
            tick();
            check("wait_req", {63'd0, bus.imem_req}, 64'd1);
            check("wait_addr", bus.imem_addr, addr0);
            check("wait_valid", {63'd0, instr_valid}, 64'd0);
            if (poke_retire) check("wait_status", {60'd0, status}, {60'd0, cur_status});
        end
        retire = 1'b0; status_we = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        exp_instr_q.push_back(word);
        tick();
        bus.imem_ack = 1'b0;
        check("exec_valid", {63'd0, instr_valid}, 64'd1);
        check("exec_req", {63'd0, bus.imem_req}, 64'd0);
        if (instr_valid && exp_instr_q.size() > 0)
            check("instruction", {32'd0, instruction}, {32'd0, exp_instr_q.pop_front()});
    endtask

    // Called with the DUT in EXEC, just after an edge.
    task automatic do_retire(input logic [1:0] sel, input logic [63:0] k, input logic [63:0] tgt,
                             input logic swe, input logic [3:0] flags,
                             input logic [63:0] exp_pc, input logic [3:0] exp_status);
        retire = 1'b1; pc_sel = sel; K = k; reg_target = tgt;
        status_we = swe; alu_flags = flags;
        exp_addr_q.push_back(exp_pc);
        tick();
        retire = 1'b0; status_we = 1'b0;
        cur_status = exp_status;
        check("ret_pc", pc, exp_pc);
        check("ret_pc_plus4", pc_plus4, exp_pc + 64'd4);
        check("ret_status", {60'd0, status}, {60'd0, exp_status});
        check("ret_valid", {63'd0, instr_valid}, 64'd0);
        if (bus.imem_req) begin
            if (exp_addr_q.size() > 0) check("ret_addr", bus.imem_addr, exp_addr_q.pop_front());
        end else begin
            check("ret_req", {63'd0, bus.imem_req}, 64'd1);
        end
    endtask

    initial begin
        reset = 1'b0; retire = 1'b0; pc_sel = 2'b00; K = '0; reg_target = '0;
        status_we = 1'b0; alu_flags = 4'b0; bus.imem_ack = 1'b0; bus.imem_rdata = '0;
        cur_status = 4'b0;

        vecs[0] = '{64'h10,  PC_INC,    64'd0,                   64'd0, 1'b0, 4'b0000, 64'h14,  4'b0000};
        vecs[1] = '{64'h100, PC_BRANCH, -64'sd2,                 64'd0, 1'b0, 4'b0000, 64'hF8,  4'b0000};
        vecs[2] = '{64'h100, PC_BRANCH, 64'd3,                   64'd0, 1'b0, 4'b0000, 64'h10C, 4'b0000};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFC, PC_INC, 64'd0,      64'd0, 1'b0, 4'b0000, 64'h0,   4'b0000};
        vecs[4] = '{64'h0,   PC_REG,    64'd0,                   64'h203, 1'b0, 4'b0000, 64'h200, 4'b0000};
        vecs[5] = '{64'h200, PC_HOLD,   64'd7,                   64'h40,  1'b0, 4'b0000, 64'h200, 4'b0000};
        vecs[6] = '{64'h40,  PC_INC,    64'd0,                   64'd0, 1'b1, 4'b1001, 64'h44,  4'b1001};
        vecs[7] = '{64'h80,  PC_BRANCH, -64'sd16,                64'd0, 1'b0, 4'b0110, 64'h40,  4'b1001};
        vecs[8] = '{64'h8,   PC_BRANCH, 64'h4000_0000_0000_0001, 64'd0, 1'b0, 4'b0000, 64'hC,   4'b1001};
        vecs[9] = '{64'h1000, PC_REG,   64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFC, 4'b0110};

        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_pc", pc, 64'h0);
            check("rst_status", {60'd0, status}, 64'd0);
            check("rst_req", {63'd0, bus.imem_req}, 64'd0);
        end
        reset = 1'b1;
        tick();
        check("first_req", {63'd0, bus.imem_req}, 64'd1);
        check("first_addr", bus.imem_addr, 64'h0);
        do_fetch(32'h91000421, 0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            do_retire(PC_REG, 64'd0, vecs[i].start_pc, 1'b0, 4'b0, vecs[i].start_pc, cur_status);
            do_fetch(32'hA000_0000 | i, 0, 1'b0);
            do_retire(vecs[i].sel, vecs[i].k, vecs[i].tgt, vecs[i].swe, vecs[i].flags,
                      vecs[i].exp_pc, vecs[i].exp_status);
            do_fetch(32'hB000_0000 | i, 0, 1'b0);
        end

        // EXEC dwell: stray ack and status_we without retire must change nothing.
        for (int i = 0; i < 3; i++) begin
            bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
            status_we = 1'b1; alu_flags = 4'b1111;
            tick();
            check("dwell_valid", {63'd0, instr_valid}, 64'd1);
            check("dwell_instr", {32'd0, instruction}, {32'd0, 32'hB000_0009});
            check("dwell_status", {60'd0, status}, {60'd0, cur_status});
        end
        bus.imem_ack = 1'b0; status_we = 1'b0;

        do_retire(PC_INC, 64'd0, 64'd0, 1'b0, 4'b0, 64'h0, cur_status);
        do_fetch(32'hC0FF_EE00, 4, 1'b1);
        check("after_wait_pc", pc, 64'h0);

        do_retire(PC_REG, 64'd0, 64'h300, 1'b1, 4'b0101, 64'h300, 4'b0101);
        reset = 1'b0;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678;
        tick();
        bus.imem_ack = 1'b0;
        check("mid_rst_req", {63'd0, bus.imem_req}, 64'd0);
        check("mid_rst_valid", {63'd0, instr_valid}, 64'd0);
        check("mid_rst_instr", {32'd0, instruction}, 64'd0);
        check("mid_rst_pc", pc, 64'h0);
        check("mid_rst_status", {60'd0, status}, 64'd0);
        reset = 1'b1; cur_status = 4'b0;
        tick();
        check("mid_rst_idle_exit", {63'd0, bus.imem_req}, 64'd1);
        do_fetch(32'h8B02_0020, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front end of the multi-cycle LEGv8 core. It owns the program counter, fetches 32-bit instructions from instruction memory over a req/ack handshake, and holds the instruction register stable for the control unit. It then retires each instruction by applying the control unit's next-PC selection, branch immediate K, and flag-write request, so it also owns the architectural status flags the control unit reads.

## Interface
Parameters:
- `RESET_PC`, default 64'h0: PC value loaded on reset.
- `K_bits`, default 64: width of the K immediate from the control unit.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-low.
- `imem_addr`  out  64: fetch address, equal to `pc`.
- `imem_req`  out  1: fetch request, held high until ack.
- `imem_ack`  in  1: read data valid this cycle. Meaningful only while `imem_req`=1.
- `imem_rdata`  in  32: instruction word.
- `instruction`  out  32: instruction register, to the control unit.
- `instr_valid`  out  1: `instruction` is valid and held.
- `pc`  out  64: current PC.
- `pc_plus4`  out  64: pc+4, the link value for BL.
- `status`  out  4: registered flags {V,C,N,Z}.
- `retire`  in  1: control unit's final state for the current instruction.
- `pc_sel`  in  2: 00 = pc+4; 01 = pc+(K<<2); 10 = reg_target; 11 = hold.
- `K`  in  K_bits: sign-extended branch offset in words.
- `reg_target`  in  64: BR target from the register file.
- `status_we`  in  1: on retire, capture `alu_flags`.
- `alu_flags`  in  4: {V,C,N,Z} from the ALU.

## Operation
The FSM has three states: IDLE, FETCH, EXEC.
- **IDLE** (reset state): no request. Next cycle goes to FETCH.
- **FETCH**: `imem_req`=1, `imem_addr`=`pc`. When `imem_ack`=1, `instruction`<=`imem_rdata` and the FSM moves to EXEC. `retire` is ignored in this state.
- **EXEC**: `instr_valid`=1 and `instruction` is frozen. Stays in EXEC for any number of cycles until `retire`=1. On retire:
  - `pc` <= next_pc.
  - If `status_we`=1, `status` <= `alu_flags`.
  - FSM moves to FETCH.
- next_pc by `pc_sel`:
  - 00: pc+4.
  - 01: pc+(K<<2).
  - 10: {reg_target[63:2],2'b00}. The low two bits are forced to zero.
  - 11: pc, i.e. the same address is refetched (halt/spin).
- Arithmetic is 64-bit modulo 2^64. Wrap-around is silent and raises no flag. K is truncated or sign-extended to 64 bits before the shift.
- `pc_plus4` is combinational from `pc` and valid in every state.
- `status_we` without `retire` has no effect.
- `imem_ack` while not in FETCH is ignored.

## Timing
- **Reset** (`reset`=0 at a rising edge), from the next edge on:
  - `pc`=RESET_PC, `status`=4'b0000, `instruction`=32'h0.
  - `instr_valid`=0, `imem_req`=0, state=IDLE.
- Reset mid-fetch drops `imem_req` the following cycle. Instruction memory must abandon a request when req falls, so no stale ack is accepted.
- After reset is released, `imem_req` rises 1 cycle later, when the FSM enters FETCH.
- **Fetch latency**:
  - Ack sampled at edge t: `instruction` and `instr_valid` are valid after edge t, with `imem_req` low in that cycle.
  - Zero-wait memory (ack in the first FETCH cycle) gives 2 cycles per fetch+retire minimum: FETCH, EXEC.
- **Retire**: sampled at edge t gives new `pc`, new `imem_addr`, `instr_valid`=0, and `imem_req`=1 after edge t.
- **Simultaneous events**:
  - Reset has priority over retire and ack.
  - Retire together with status_we updates pc and status on the same edge.
- All outputs are registered except `pc_plus4` and `imem_addr`, which are pure functions of `pc`, and the state-decoded `imem_req`/`instr_valid`.

## Structure
- Shared package `fetch_pkg`:
  - FSM state encoding (IDLE, FETCH, EXEC).
  - `pc_sel` constants (PC_INC, PC_BRANCH, PC_REG, PC_HOLD).
  - Default RESET_PC.
  - The control unit uses the same `pc_sel` constants when building its control word.
- One sub-module, `pc_next_logic`: a combinational next-PC mux and adders (pc+4, pc+(K<<2), register alignment). The FSM, PC, IR and status registers stay in the top.

## Test plan
- **Reset and first fetch**: hold `reset`=0 for 3 cycles, then release with zero-wait ack and `imem_rdata`=32'h91000421.
  - `pc`=0, `status`=0 during reset.
  - `imem_req` rises 1 cycle after release.
  - `instruction`=32'h91000421 and `instr_valid`=1 on the next cycle.
- **Sequential retire**: retire with pc_sel=00 at pc=0x10.
  - Next `imem_addr`=0x14, `pc_plus4`=0x18.
- **Branch offset**, at pc=0x100:
  - pc_sel=01, K=-2: pc becomes 0xF8.
  - pc_sel=01, K=3: pc becomes 0x10C.
  - pc=64'hFFFF_FFFF_FFFF_FFFC with pc_sel=00 wraps to 0.
- **Register branch and hold**: pc_sel=10 with reg_target=0x203, then pc_sel=11.
  - pc=0x200 after the first retire, and still 0x200 after the second.
  - The same address is requested again.
- **Wait states and flags**:
  - Ack delayed 4 cycles: `imem_req` is held high, `imem_addr` is stable, `instr_valid`=0 throughout.
  - Retire with status_we=1, alu_flags=4'b1001: status=4'b1001 after the edge.
  - status_we=1 without retire: status unchanged.
- **Reset mid-operation**: assert reset during FETCH with ack arriving the same cycle.
  - Ack is discarded and state returns to IDLE.
  - `instruction`=0, `instr_valid`=0, `pc`=RESET_PC.
